// File: rtl/fb_arb_pkg.sv
// Shared types and frame buffer geometry
// for the frame buffer write arbiter.
package fb_arb_pkg;

   typedef enum logic {IDLE, BURST} arb_state_t;

   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 8;
   localparam int FB_PIXELS = 307200;

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the
// request vector past the last owner, take the lowest set bit.
module rr_pick
   import fb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         prev_owner,
   output logic               valid,
   output logic [2:0]         winner
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REQ - 1);
   localparam logic [3:0] N4       = 4'(NUM_REQ);

   logic [3:0]           start;
   logic [3:0]           idx;
   logic [3:0]           sum;
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;

   always_comb begin
      start = '0;
      if ({1'b0, prev_owner} < LAST_IDX) begin
         start = {1'b0, prev_owner} + 4'd1;
      end
      dbl = {req, req} >> start;
      rot = NUM_REQ'(dbl);
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            idx = 4'(i);
         end
      end
      sum = start + idx;
      if (sum >= N4) begin
         sum = sum - N4;
      end
      winner = 3'(sum);
      valid  = |req;
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the frame buffer write port
// between burst-writing pixel engines, with burst length cap.
module fb_write_arbiter
   import fb_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int MAX_BURST = 64
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        last,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         fb_wraddress,
   output logic [DATA_W-1:0]         fb_data,
   output logic                      fb_wren,
   output logic                      busy,
   output logic [2:0]                owner
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t         state;
   logic [2:0]         prev_owner;
   logic [CNT_W-1:0]   beat_cnt;
   logic               pick_valid;
   logic [2:0]         pick_idx;
   logic               beat;
   logic               last_beat;
   logic               release_now;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req        (req),
      .prev_owner (prev_owner),
      .valid      (pick_valid),
      .winner     (pick_idx)
   );

   // gnt is one-hot, so it doubles as the owner's select mask
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign beat        = (state == BURST) && |(req & gnt);
   assign last_beat   = |(req & gnt & last);
   assign release_now = beat &&
      (last_beat || beat_cnt == CNT_W'(MAX_BURST - 1));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         gnt          <= '0;
         owner        <= '0;
         prev_owner   <= 3'(NUM_REQ - 1);
         beat_cnt     <= '0;
         busy         <= 1'b0;
         fb_wren      <= 1'b0;
         fb_wraddress <= '0;
         fb_data      <= '0;
      end else begin
         fb_wren <= beat;
         if (beat) begin
            fb_wraddress <= sel_addr;
            fb_data      <= sel_data;
         end
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt      <= NUM_REQ'(1) << pick_idx;
                  owner    <= pick_idx;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (release_now) begin
                  gnt        <= '0;
                  busy       <= 1'b0;
                  prev_owner <= owner;
                  state      <= IDLE;
               end else if (beat) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: reset, single burst,
// fairness, forced release, stall, reset mid-burst, ignored inputs.
module tb_fb_write_arbiter;

   logic        Clk;
   logic        Reset;
   logic [3:0]  req;
   logic [3:0]  last;
   logic [75:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic [18:0] fb_wraddress;
   logic [7:0]  fb_data;
   logic        fb_wren;
   logic        busy;
   logic [2:0]  owner;

   int vecs = 0;
   int errs = 0;

   fb_write_arbiter dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .req          (req),
      .last         (last),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .gnt          (gnt),
      .fb_wraddress (fb_wraddress),
      .fb_data      (fb_data),
      .fb_wren      (fb_wren),
      .busy         (busy),
      .owner        (owner)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      req   = '0;
      last  = '0;
      step();
      Reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      req = '0; last = '0; req_addr = '0; req_data = '0;
      step();
      step();
      vecs++;
      if (gnt !== 4'b0000 || fb_wren !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_ctl got gnt=%b wren=%b busy=%b want 0000/0/0",
                  gnt, fb_wren, busy);
      end
      vecs++;
      if (fb_wraddress !== 19'd0 || fb_data !== 8'd0 || owner !== 3'd0) begin
         errs++;
         $display("FAIL rst_data got addr=%0d data=%h owner=%0d want 0/00/0",
                  fb_wraddress, fb_data, owner);
      end
      Reset = 1'b0;
      step();
   endtask

   task automatic test_single();
      req = 4'b0100;
      req_addr[2*19 +: 19] = 19'd100;
      req_data[2*8 +: 8]   = 8'hA0;
      step();
      vecs++;
      if (gnt !== 4'b0100 || busy !== 1'b1 || fb_wren !== 1'b0) begin
         errs++;
         $display("FAIL sgl_gnt got gnt=%b busy=%b wren=%b want 0100/1/0",
                  gnt, busy, fb_wren);
      end
      for (int i = 0; i < 4; i++) begin
         req_addr[2*19 +: 19] = 19'(100 + i);
         req_data[2*8 +: 8]   = 8'(8'hA0 + i);
         last = (i == 3) ? 4'b0100 : 4'b0000;
         step();
         vecs++;
         if (fb_wren !== 1'b1 || fb_wraddress !== 19'(100 + i) ||
             fb_data !== 8'(8'hA0 + i)) begin
            errs++;
            $display("FAIL sgl_wr%0d got wren=%b addr=%0d data=%h want 1/%0d/%h",
                     i, fb_wren, fb_wraddress, fb_data, 100 + i, 8'hA0 + i);
         end
         vecs++;
         if (gnt !== ((i == 3) ? 4'b0000 : 4'b0100)) begin
            errs++;
            $display("FAIL sgl_hold%0d got gnt=%b", i, gnt);
         end
      end
      req = '0; last = '0;
      step();
      vecs++;
      if (fb_wren !== 1'b0 || busy !== 1'b0 || owner !== 3'd2) begin
         errs++;
         $display("FAIL sgl_end got wren=%b busy=%b owner=%0d want 0/0/2",
                  fb_wren, busy, owner);
      end
   endtask

   task automatic test_fairness();
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111; last = '0;
      step();
      for (int k = 0; k < 5; k++) begin
         vecs++;
         if (gnt !== 4'(1 << order[k])) begin
            errs++;
            $display("FAIL fair_gnt%0d got %b want %b", k, gnt, 4'(1 << order[k]));
         end
         last = '0;
         step();
         last = 4'b1111;
         step();
         vecs++;
         if (gnt !== 4'b0000 || fb_wren !== 1'b1) begin
            errs++;
            $display("FAIL fair_bubble%0d got gnt=%b wren=%b want 0000/1",
                     k, gnt, fb_wren);
         end
         last = '0;
         if (k == 4) req = '0;
         step();
      end
      vecs++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         errs++;
         $display("FAIL fair_end got gnt=%b busy=%b want 0000/0", gnt, busy);
      end
   endtask

   task automatic test_forced_release();
      int writes = 0;
      do_reset();
      req = 4'b1010; last = '0;
      req_addr[3*19 +: 19] = 19'd5000;
      step();
      vecs++;
      if (gnt !== 4'b0010) begin
         errs++;
         $display("FAIL frc_gnt got %b want 0010", gnt);
      end
      for (int i = 0; i < 64; i++) begin
         req_addr[1*19 +: 19] = 19'(i);
         step();
         if (fb_wren === 1'b1) writes++;
         if (i == 62) begin
            vecs++;
            if (gnt !== 4'b0010) begin
               errs++;
               $display("FAIL frc_hold63 got gnt=%b want 0010", gnt);
            end
         end
      end
      vecs++;
      if (writes != 64 || gnt !== 4'b0000 || fb_wraddress !== 19'd63) begin
         errs++;
         $display("FAIL frc_cap got writes=%0d gnt=%b addr=%0d want 64/0000/63",
                  writes, gnt, fb_wraddress);
      end
      last = 4'b1000;
      step();
      vecs++;
      if (gnt !== 4'b1000 || fb_wren !== 1'b0) begin
         errs++;
         $display("FAIL frc_next got gnt=%b wren=%b want 1000/0", gnt, fb_wren);
      end
      step();
      vecs++;
      if (gnt !== 4'b0000 || fb_wren !== 1'b1 || fb_wraddress !== 19'd5000) begin
         errs++;
         $display("FAIL frc_r3 got gnt=%b wren=%b addr=%0d want 0000/1/5000",
                  gnt, fb_wren, fb_wraddress);
      end
      last = '0;
      step();
      vecs++;
      if (gnt !== 4'b0010) begin
         errs++;
         $display("FAIL frc_regain got %b want 0010", gnt);
      end
      last = 4'b0010;
      step();
      req = '0; last = '0;
      step();
   endtask

   task automatic test_stall();
      bit pat [11] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
      int n = 0;
      int writes = 0;
      do_reset();
      req = 4'b0001; last = '0;
      step();
      for (int c = 0; c < 11; c++) begin
         req = {3'b000, pat[c]};
         req_addr[18:0] = 19'(200 + n);
         last = (pat[c] && n == 5) ? 4'b0001 : 4'b0000;
         step();
         if (fb_wren === 1'b1) writes++;
         if (pat[c]) begin
            vecs++;
            if (fb_wren !== 1'b1 || fb_wraddress !== 19'(200 + n)) begin
               errs++;
               $display("FAIL stl_beat%0d got wren=%b addr=%0d want 1/%0d",
                        n, fb_wren, fb_wraddress, 200 + n);
            end
            n++;
         end else begin
            vecs++;
            if (fb_wren !== 1'b0 || gnt !== 4'b0001) begin
               errs++;
               $display("FAIL stl_idle%0d got wren=%b gnt=%b want 0/0001",
                        c, fb_wren, gnt);
            end
         end
      end
      vecs++;
      if (writes != 6 || gnt !== 4'b0000) begin
         errs++;
         $display("FAIL stl_total got writes=%0d gnt=%b want 6/0000",
                  writes, gnt);
      end
      req = '0; last = '0;
      step();
   endtask

   task automatic test_reset_mid_and_ignored();
      do_reset();
      req = 4'b0100; last = '0;
      step();
      for (int i = 0; i < 10; i++) begin
         req_addr[2*19 +: 19] = 19'(400 + i);
         step();
      end
      Reset = 1'b1;
      #1;
      vecs++;
      if (gnt !== 4'b0000 || fb_wren !== 1'b0 || busy !== 1'b0 ||
          owner !== 3'd0) begin
         errs++;
         $display("FAIL rmid_async got gnt=%b wren=%b busy=%b owner=%0d want 0",
                  gnt, fb_wren, busy, owner);
      end
      req = 4'b0101;
      step();
      Reset = 1'b0;
      step();
      vecs++;
      if (gnt !== 4'b0001 || fb_wren !== 1'b0) begin
         errs++;
         $display("FAIL rmid_first got gnt=%b wren=%b want 0001/0", gnt, fb_wren);
      end
      req_addr[1*19 +: 19] = 19'd999;
      for (int i = 0; i < 4; i++) begin
         req  = {2'b00, 1'(i % 2), 1'b1};
         last = {2'b00, 1'((i + 1) % 2), 1'b0};
         req_addr[18:0] = 19'(300 + i);
         step();
         vecs++;
         if (gnt !== 4'b0001 || fb_wren !== 1'b1 ||
             fb_wraddress !== 19'(300 + i)) begin
            errs++;
            $display("FAIL ign_beat%0d got gnt=%b wren=%b addr=%0d want 0001/1/%0d",
                     i, gnt, fb_wren, fb_wraddress, 300 + i);
         end
      end
      req = 4'b0010; last = 4'b0010;
      step();
      vecs++;
      if (gnt !== 4'b0001 || fb_wren !== 1'b0 || fb_wraddress !== 19'd303) begin
         errs++;
         $display("FAIL ign_other got gnt=%b wren=%b addr=%0d want 0001/0/303",
                  gnt, fb_wren, fb_wraddress);
      end
      req = 4'b0001; last = 4'b0001;
      req_addr[18:0] = 19'd304;
      step();
      vecs++;
      if (gnt !== 4'b0000 || fb_wraddress !== 19'd304) begin
         errs++;
         $display("FAIL ign_end got gnt=%b addr=%0d want 0000/304",
                  gnt, fb_wraddress);
      end
      req = '0; last = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_forced_release();
      test_stall();
      test_reset_mid_and_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
